ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 9 +
 rtl/ram_arbiter_if.sv | 9 +
 rtl/ram_arbiter_rr_arb2.sv | 17 +
 rtl/ram_arbiter.sv | 99 +++++++++
 tb/tb_ram_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths, FSM state encoding and requester IDs for ram_arbiter
package ram_arb_pkg;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   typedef enum logic [2:0] {IDLE, WR, RD1, RD2, DONE} state_t;
   typedef logic id_t;
   localparam id_t ID_CPU = 1'b0;
   localparam id_t ID_LDR = 1'b1;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's access handshake (req/we/addr/wdata toward the arbiter, ack/rdata back)
interface ram_arbiter_if;
   import ram_arb_pkg::*;
   logic req, we, ack;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata, rdata;
   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: stateless two-way round-robin pick; ptr names the requester favoured on a tie
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic req_cpu,
   input  logic req_ldr,
   input  id_t  ptr,
   input  logic adv,
   output id_t  gnt,
   output id_t  ptr_nxt
);
   // tie goes to ptr; once a grant is taken the other requester becomes favoured
   always_comb begin
      gnt = (req_cpu && req_ldr) ? ptr : (req_ldr ? ID_LDR : ID_CPU);
      ptr_nxt = adv ? ~gnt : ptr;
   end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous RAM between CPU and loader; RAM_ARB_LOCK_EN adds ldr_lock (loader-exclusive grants)
module ram_arbiter
   import ram_arb_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
`ifdef RAM_ARB_LOCK_EN
   input  logic              ldr_lock,
`endif
   ram_arbiter_if.slave      cpu,
   ram_arbiter_if.slave      ldr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_cs,
   output logic              ram_oa,
   output logic              ram_wa,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);
   state_t state_q, state_d;
   id_t gid_q, gid_d, ptr_q, ptr_d, gnt;
   logic we_q, we_d, cpu_req, req_any;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, ldr_rdata_q, ldr_rdata_d;
`ifdef RAM_ARB_LOCK_EN
   assign cpu_req = cpu.req & ~ldr_lock;
`else
   assign cpu_req = cpu.req;
`endif
   assign req_any = cpu_req | ldr.req;
   rr_arb2 u_arb (
      .req_cpu (cpu_req),
      .req_ldr (ldr.req),
      .ptr     (ptr_q),
      .adv     (state_q == IDLE && req_any),
      .gnt     (gnt),
      .ptr_nxt (ptr_d)
   );
   // next state: grant and latch fields in IDLE, capture read data at the end of RD2
   always_comb begin
      state_d = state_q;
      gid_d = gid_q;
      we_d = we_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;
      case (state_q)
         IDLE: if (req_any) begin
            gid_d = gnt;
            we_d = (gnt == ID_LDR) ? ldr.we : cpu.we;
            addr_d = (gnt == ID_LDR) ? ldr.addr : cpu.addr;
            wdata_d = (gnt == ID_LDR) ? ldr.wdata : cpu.wdata;
            state_d = we_d ? WR : RD1;
         end
         WR: state_d = DONE;
         RD1: state_d = RD2;
         RD2: begin
            if (gid_q == ID_LDR) ldr_rdata_d = ram_rdata;
            else cpu_rdata_d = ram_rdata;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state registers; reset favours the CPU on the first tie
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         gid_q <= ID_CPU;
         ptr_q <= ID_CPU;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         gid_q <= gid_d;
         ptr_q <= ptr_d;
         we_q <= we_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
      end
   end
   // chip select is cut by clr so a reset edge never commits a write or a read-register load
   assign ram_cs = (state_q inside {WR, RD1, RD2}) & ~clr;
   assign ram_wa = state_q == WR;
   assign ram_oa = state_q inside {RD1, RD2};
   assign ram_addr = addr_q;
   assign ram_wdata = wdata_q;
   assign busy = state_q != IDLE;
   assign cpu.ack = state_q == DONE && gid_q == ID_CPU;
   assign ldr.ack = state_q == DONE && gid_q == ID_LDR;
   assign cpu.rdata = cpu_rdata_q;
   assign ldr.rdata = ldr_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;
   logic clk, clr, ldr_lock;
   logic [3:0] ram_addr;
   logic ram_cs, ram_oa, ram_wa, busy;
   logic [7:0] ram_wdata, ram_rdata;
   ram_arbiter_if cpu_if ();
   ram_arbiter_if ldr_if ();
   ram_arbiter dut (
      .clk       (clk),
      .clr       (clr),
`ifdef RAM_ARB_LOCK_EN
      .ldr_lock  (ldr_lock),
`endif
      .cpu       (cpu_if),
      .ldr       (ldr_if),
      .ram_addr  (ram_addr),
      .ram_cs    (ram_cs),
      .ram_oa    (ram_oa),
      .ram_wa    (ram_wa),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .busy      (busy)
   );
   int checks = 0, errors = 0;
   bit mon_en = 0;
   bit order[$];
   initial clk = 0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   // synchronous RAM: write, or load the output register, at an edge with cs
   logic [7:0] mem [16];
   logic [7:0] rout = 8'h00;
   initial foreach (mem[i]) mem[i] = 8'h00;
   always @(posedge clk) begin
      if (ram_cs && ram_wa) mem[ram_addr] <= ram_wdata;
      if (ram_cs && ram_oa) rout <= mem[ram_addr];
   end
   assign ram_rdata = rout;
   // reference model: who wins each grant edge, when its ack lands, what memory holds
   logic [7:0] refmem [16];
   initial foreach (refmem[i]) refmem[i] = 8'h00;
   int edge_n = 0, grant_e = 0, ack_e = 0, free_e = 0;
   bit m_act = 0, own = 0, last = 1, m_we = 0, creq, lreq;
   logic [3:0] m_a;
   logic [7:0] m_d, exp_rd [2];
   initial begin exp_rd[0] = 8'h00; exp_rd[1] = 8'h00; end
   always @(posedge clk) begin
      edge_n++;
      if (clr) begin
         m_act = 0; last = 1; free_e = edge_n + 1;
         exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
      end else begin
         if (m_act && edge_n == ack_e) begin
            if (m_we) refmem[m_a] = m_d;
            else exp_rd[own] = refmem[m_a];
         end
         creq = cpu_if.req & ~ldr_lock;
         lreq = ldr_if.req;
         if (edge_n >= free_e && (creq || lreq)) begin
            own = (creq && lreq) ? ~last : lreq;
            last = own;
            m_we = own ? ldr_if.we : cpu_if.we;
            m_a = own ? ldr_if.addr : cpu_if.addr;
            m_d = own ? ldr_if.wdata : cpu_if.wdata;
            grant_e = edge_n;
            ack_e = edge_n + (m_we ? 1 : 2);
            free_e = ack_e + 2;
            m_act = 1;
         end
      end
   end
   // per-cycle comparison of outputs with the model, just after each edge
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         automatic bit win = m_act && edge_n >= grant_e && edge_n < ack_e;
         automatic bit ackn = m_act && edge_n == ack_e;
         check("cpu_ack", cpu_if.ack, ackn && !own);
         check("ldr_ack", ldr_if.ack, ackn && own);
         check("busy", busy, m_act && edge_n >= grant_e && edge_n <= ack_e);
         check("ram_cs", ram_cs, win && !clr);
         check("ram_wa", ram_wa, win && m_we);
         check("ram_oa", ram_oa, win && !m_we);
         check("oa_wa_excl", ram_oa & ram_wa, 0);
         check("cpu_rdata", cpu_if.rdata, exp_rd[0]);
         check("ldr_rdata", ldr_if.rdata, exp_rd[1]);
      end
   end
   // one access on port p (0 cpu, 1 ldr); call at a negedge, returns at the negedge showing ack
   task automatic drive(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d, output int lat);
      bit ack;
      lat = 0;
      if (p) begin ldr_if.we = we; ldr_if.addr = a; ldr_if.wdata = d; ldr_if.req = 1; end
      else begin cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = d; cpu_if.req = 1; end
      do begin
         @(negedge clk);
         lat++;
         ack = p ? ldr_if.ack : cpu_if.ack;
      end while (!ack && lat < 60);
      check(p ? "ldr_ack_seen" : "cpu_ack_seen", ack, 1);
      order.push_back(p);
      if (p) ldr_if.req = 0; else cpu_if.req = 0;
   endtask
   initial begin
      int lat, l0, l1;
      cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = 0; cpu_if.wdata = 0;
      ldr_if.req = 0; ldr_if.we = 0; ldr_if.addr = 0; ldr_if.wdata = 0;
      ldr_lock = 0;
      clr = 1;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_cpu_ack", cpu_if.ack, 0);
      check("rst_ldr_ack", ldr_if.ack, 0);
      check("rst_cs", ram_cs, 0);
      check("rst_oa", ram_oa, 0);
      check("rst_wa", ram_wa, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_wdata", ram_wdata, 0);
      check("rst_cpu_rdata", cpu_if.rdata, 0);
      check("rst_ldr_rdata", ldr_if.rdata, 0);
      clr = 0;
      mon_en = 1;
      // reset during WR must abort the write of FF to address 7
      ldr_if.we = 1; ldr_if.addr = 4'h7; ldr_if.wdata = 8'hFF; ldr_if.req = 1;
      @(negedge clk);
      check("abort_in_wr", ram_wa, 1);
      clr = 1; ldr_if.req = 0;
      #1 check("cs_gated", ram_cs, 0);
      @(negedge clk);
      clr = 0;
      check("abort_idle", busy, 0);
      drive(1, 0, 4'h7, 8'h00, lat);
      check("abort_rd7", ldr_if.rdata, 8'h00);
      @(negedge clk);
      // loader write then read, isolated latencies
      drive(1, 1, 4'h3, 8'hA5, lat);
      check("wr_lat", lat, 2);
      @(negedge clk);
      drive(1, 0, 4'h3, 8'h00, lat);
      check("rd_lat", lat, 3);
      check("rd_a5", ldr_if.rdata, 8'hA5);
      // both requesting from reset: CPU first, then strict alternation
      clr = 1;
      @(negedge clk);
      clr = 0;
      order.delete();
      fork
         for (int i = 0; i < 3; i++) drive(0, 0, 4'(i), 8'h00, l0);
         for (int i = 0; i < 3; i++) drive(1, 0, 4'(i + 8), 8'h00, l1);
      join
      foreach (order[i]) check($sformatf("rr_order%0d", i), order[i], i % 2);
      // fill via loader, read back via CPU
      for (int a = 0; a < 16; a++) drive(1, 1, 4'(a), 8'(8'h10 + a), lat);
      for (int a = 0; a < 16; a++) begin
         drive(0, 0, 4'(a), 8'h00, lat);
         check($sformatf("fill_rd%0d", a), cpu_if.rdata, 8'(8'h10 + a));
      end
      // random concurrent traffic; the per-cycle monitor does the checking
      fork
         for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), l0);
         end
         for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), l1);
         end
      join
`ifdef RAM_ARB_LOCK_EN
      // lock keeps a pending CPU read waiting through 4 loader accesses
      @(negedge clk);
      ldr_lock = 1;
      order.delete();
      fork
         drive(0, 0, 4'h5, 8'h00, l0);
         begin
            for (int i = 0; i < 4; i++) drive(1, 0, 4'(i), 8'h00, l1);
            ldr_lock = 0;
            drive(1, 0, 4'h9, 8'h00, l1);
         end
      join
      foreach (order[i]) check($sformatf("lock_order%0d", i), order[i], i == 4 ? 0 : 1);
`endif
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
